// File: rtl/nes_controller_pkg.sv
// ============================================================================
// nes_controller_pkg : shared NES joypad bit map and width constants (rev 1.0)
// ============================================================================
`default_nettype none

package nes_controller_pkg;

    localparam int CONTROLLER_BITS = 8;
    localparam int BIT_COUNT_W     = 4;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Bits-shifted counter stops at one full report.
    function automatic logic [BIT_COUNT_W-1:0] bit_count_next(input logic [BIT_COUNT_W-1:0] cnt);
        return (cnt >= BIT_COUNT_W'(CONTROLLER_BITS)) ? cnt : cnt + BIT_COUNT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nes_controller_responder_if.sv
// ============================================================================
// nes_controller_responder_if : host-facing joypad pins plus debug taps (rev 1.0)
// ============================================================================
`default_nettype none

interface nes_controller_responder_if;
    import nes_controller_pkg::*;

    logic [CONTROLLER_BITS-1:0] i_buttons;
    logic                       i_latch;
    logic                       i_shift_clk;
    logic                       o_data;
    logic [CONTROLLER_BITS-1:0] o_buttons_debounced;
    logic [BIT_COUNT_W-1:0]     o_bit_count;

    modport master (
        output i_buttons, i_latch, i_shift_clk,
        input  o_data, o_buttons_debounced, o_bit_count
    );

    modport slave (
        input  i_buttons, i_latch, i_shift_clk,
        output o_data, o_buttons_debounced, o_bit_count
    );

endinterface

`default_nettype wire

// File: rtl/nes_button_debouncer.sv
// ============================================================================
// nes_button_debouncer : one-button synchroniser + stable-count debouncer (rev 1.0)
// ============================================================================
`default_nettype none

module nes_button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  wire logic i_clk,
    input  wire logic i_reset_n,
    input  wire logic i_button,
    output logic      o_stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   synced;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_button};
        synced = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign o_stable = synced;
        end else begin : g_debounce
            localparam int            CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_q;
            logic             stable_d;

            // Counter tracks the current run of disagreeing samples; it tops out at LAST.
            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (synced == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    stable_d = ~stable_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign o_stable = stable_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/nes_controller_responder.sv
// ============================================================================
// nes_controller_responder : 4021-style joypad responder for the NES host (rev 1.0)
// ============================================================================
`default_nettype none

module nes_controller_responder
    import nes_controller_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_reset_n,
    nes_controller_responder_if.slave bus
);

    logic [SYNC_STAGES-1:0]     latch_sync_q;
    logic [SYNC_STAGES-1:0]     latch_sync_d;
    logic [SYNC_STAGES-1:0]     clk_sync_q;
    logic [SYNC_STAGES-1:0]     clk_sync_d;
    logic                       clk_prev_q;
    logic                       clk_prev_d;
    logic [CONTROLLER_BITS-1:0] shift_reg_q;
    logic [CONTROLLER_BITS-1:0] shift_reg_d;
    logic [BIT_COUNT_W-1:0]     bit_count_q;
    logic [BIT_COUNT_W-1:0]     bit_count_d;
    logic [CONTROLLER_BITS-1:0] debounced;
    logic                       latch_s;
    logic                       clk_s;
    logic                       rise;

    generate
        for (genvar i = 0; i < CONTROLLER_BITS; i++) begin : g_btn
            nes_button_debouncer #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debouncer (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .i_button  (bus.i_buttons[i]),
                .o_stable  (debounced[i])
            );
        end
    endgenerate

    // Latch wins over a shift edge in the same cycle; emptied positions refill with 1.
    always_comb begin
        latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], bus.i_latch};
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], bus.i_shift_clk};
        latch_s      = latch_sync_q[SYNC_STAGES-1];
        clk_s        = clk_sync_q[SYNC_STAGES-1];
        rise         = clk_s & ~clk_prev_q;
        clk_prev_d   = clk_s;
        shift_reg_d  = shift_reg_q;
        bit_count_d  = bit_count_q;
        if (latch_s) begin
            shift_reg_d = debounced;
            bit_count_d = '0;
        end else if (rise) begin
            shift_reg_d = {1'b1, shift_reg_q[CONTROLLER_BITS-1:1]};
            bit_count_d = bit_count_next(bit_count_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '0;
            clk_prev_q   <= 1'b1;
            shift_reg_q  <= '0;
            bit_count_q  <= '0;
        end else begin
            latch_sync_q <= latch_sync_d;
            clk_sync_q   <= clk_sync_d;
            clk_prev_q   <= clk_prev_d;
            shift_reg_q  <= shift_reg_d;
            bit_count_q  <= bit_count_d;
        end
    end

    assign bus.o_data              = shift_reg_q[BTN_A];
    assign bus.o_buttons_debounced = debounced;
    assign bus.o_bit_count         = bit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_controller_responder.sv
// ============================================================================
// tb_nes_controller_responder : directed tables + randomized model comparison
// ============================================================================
`default_nettype none

module tb_nes_controller_responder;
    import nes_controller_pkg::*;

    localparam int SYNC = 2;
    localparam int DC   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    nes_controller_responder_if bus  ();
    nes_controller_responder_if bus0 ();

    nes_controller_responder #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
    );
    nes_controller_responder #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw-input history; each edge acts on the sample taken SYNC+1 cycles back.
    logic [7:0] h_btn[$];
    bit         h_latch[$];
    bit         h_clk[$];
    logic [7:0] m_deb;
    bit         m_q[$];
    int         m_cnt;

    task automatic model_reset();
        h_btn = {}; h_latch = {}; h_clk = {};
        for (int i = 0; i < DC + 3; i++) h_btn.push_back(8'h00);
        h_latch.push_back(1'b0); h_latch.push_back(1'b0); h_latch.push_back(1'b0);
        h_clk.push_back(1'b1);   h_clk.push_back(1'b0);   h_clk.push_back(1'b0);
        m_deb = 8'h00;
        m_q   = {};
        for (int i = 0; i < CONTROLLER_BITS; i++) m_q.push_back(1'b0);
        m_cnt = 0;
    endtask

    task automatic model_edge();
        int         n;
        bit         l, c, cp, diff;
        logic [7:0] nd;
        n  = h_latch.size();
        l  = h_latch[n-3];
        c  = h_clk[n-3];
        cp = h_clk[n-4];
        if (l) begin
            m_q = {};
            for (int i = 0; i < CONTROLLER_BITS; i++) m_q.push_back(m_deb[i]);
            m_cnt = 0;
        end else if (c && !cp) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (m_cnt < CONTROLLER_BITS) m_cnt++;
        end
        // A button flips once its last DC samples all disagree with the accepted value.
        nd = m_deb;
        n  = h_btn.size();
        for (int b = 0; b < CONTROLLER_BITS; b++) begin
            diff = 1'b1;
            for (int j = 0; j < DC; j++)
                if (h_btn[n-3-j][b] == m_deb[b]) diff = 1'b0;
            if (diff) nd[b] = ~m_deb[b];
        end
        m_deb = nd;
        while (h_btn.size() > 32)   void'(h_btn.pop_front());
        while (h_latch.size() > 32) void'(h_latch.pop_front());
        while (h_clk.size() > 32)   void'(h_clk.pop_front());
    endtask

    function automatic logic model_data();
        return (m_q.size() > 0) ? m_q[0] : 1'b1;
    endfunction

    task automatic tick();
        h_btn.push_back(bus.i_buttons);
        h_latch.push_back(bus.i_latch);
        h_clk.push_back(bus.i_shift_clk);
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else        model_edge();
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        bit   latch;
        bit   sclk;
        int   cycles;
        logic exp_data;
        int   exp_cnt;
    } vec_t;

    vec_t       tbl[26];
    logic [7:0] prev0;
    logic [7:0] pats0[4];
    bit         rd[12];

    initial begin
        bus.i_buttons  = 8'h00; bus.i_latch  = 1'b0; bus.i_shift_clk  = 1'b1;
        bus0.i_buttons = 8'h00; bus0.i_latch = 1'b0; bus0.i_shift_clk = 1'b1;
        model_reset();
        hold(3);
        check("rst_data", bus.o_data, 0);
        check("rst_cnt", bus.o_bit_count, 0);
        check("rst_deb", bus.o_buttons_debounced, 0);
        check("rst_deb0", bus0.o_buttons_debounced, 0);
        rst_n = 1'b1;
        hold(4);

        // Basic read: load 8'b1000_0101, then twelve shift-clock rises.
        bus.i_buttons = 8'b1000_0101;
        hold(10);
        check("deb_85", bus.o_buttons_debounced, 8'h85);
        rd = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[0] = '{1'b1, 1'b1, 4, 1'b1, 0};
        tbl[1] = '{1'b0, 1'b1, 4, 1'b1, 0};
        for (int k = 0; k < 12; k++) begin
            tbl[2 + 2*k] = '{1'b0, 1'b0, 4, (k == 0) ? 1'b1 : rd[k-1], (k > 8) ? 8 : k};
            tbl[3 + 2*k] = '{1'b0, 1'b1, 4, rd[k], (k + 1 > 8) ? 8 : k + 1};
        end
        for (int i = 0; i < 26; i++) begin
            bus.i_latch     = tbl[i].latch;
            bus.i_shift_clk = tbl[i].sclk;
            hold(tbl[i].cycles);
            check($sformatf("read%0d_data", i), bus.o_data, tbl[i].exp_data);
            check($sformatf("read%0d_cnt", i), bus.o_bit_count, tbl[i].exp_cnt);
        end

        // Latency: one rise moves B onto o_data exactly SYNC+1 cycles later.
        bus.i_latch = 1'b1; hold(4);
        bus.i_latch = 1'b0; hold(4);
        bus.i_shift_clk = 1'b0; hold(4);
        bus.i_shift_clk = 1'b1;
        hold(2);
        check("lat_before", bus.o_data, 1);
        hold(1);
        check("lat_at3", bus.o_data, 0);

        // Latch held: live button changes reach o_data, shift rises ignored.
        bus.i_latch = 1'b1; hold(4);
        check("lh_data", bus.o_data, 1);
        bus.i_shift_clk = 1'b0; hold(4);
        bus.i_shift_clk = 1'b1; hold(4);
        check("lh_rise_cnt", bus.o_bit_count, 0);
        check("lh_rise_data", bus.o_data, 1);
        bus.i_buttons = 8'h84;
        hold(6);
        check("lh_deb", bus.o_buttons_debounced, 8'h84);
        check("lh_data_old", bus.o_data, 1);
        hold(1);
        check("lh_data_new", bus.o_data, 0);
        bus.i_buttons = 8'h85;
        hold(7);
        check("lh_data_back", bus.o_data, 1);
        check("lh_cnt", bus.o_bit_count, 0);
        bus.i_latch = 1'b0; hold(4);

        // Bounce on A: toggling every 2 cycles never settles; final edge accepted after SYNC+4.
        bus.i_buttons = 8'h84; hold(8);
        check("bnc_start", bus.o_buttons_debounced, 8'h84);
        for (int i = 0; i < 20; i++) begin
            bus.i_buttons[0] = ((i / 2) % 2) == 0;
            tick();
            check($sformatf("bnc_t%0d", i), bus.o_buttons_debounced[0], 0);
        end
        bus.i_buttons[0] = 1'b1;
        hold(SYNC + 3);
        check("bnc_early", bus.o_buttons_debounced[0], 0);
        hold(1);
        check("bnc_final", bus.o_buttons_debounced[0], 1);

        // Reset mid-shift, then a normal reload.
        bus.i_latch = 1'b1; hold(4);
        bus.i_latch = 1'b0; hold(4);
        for (int k = 0; k < 3; k++) begin
            bus.i_shift_clk = 1'b0; hold(4);
            bus.i_shift_clk = 1'b1; hold(4);
        end
        check("mid_cnt", bus.o_bit_count, 3);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_data", bus.o_data, 0);
        check("mid_rst_cnt", bus.o_bit_count, 0);
        check("mid_rst_deb", bus.o_buttons_debounced, 0);
        hold(2);
        rst_n = 1'b1;
        hold(10);
        bus.i_latch = 1'b1; hold(4);
        check("rel_data", bus.o_data, 1);
        check("rel_cnt", bus.o_bit_count, 0);
        check("rel_deb", bus.o_buttons_debounced, 8'h85);
        bus.i_latch = 1'b0; hold(4);

        // Debounce bypass: change visible exactly two cycles after the input.
        pats0 = '{8'h5A, 8'hFF, 8'h00, 8'h81};
        for (int p = 0; p < 4; p++) begin
            prev0 = bus0.o_buttons_debounced;
            bus0.i_buttons = pats0[p];
            tick();
            check($sformatf("byp%0d_early", p), bus0.o_buttons_debounced, prev0);
            tick();
            check($sformatf("byp%0d", p), bus0.o_buttons_debounced, pats0[p]);
            hold(2);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 5) == 0) bus.i_latch = ~bus.i_latch;
            if ($urandom_range(0, 2) == 0) bus.i_shift_clk = ~bus.i_shift_clk;
            case ($urandom_range(0, 11))
                0:       bus.i_buttons = 8'($urandom);
                1, 2:    bus.i_buttons[$urandom_range(0, 7)] = ~bus.i_buttons[$urandom_range(0, 7)];
                default: ;
            endcase
            tick();
            check($sformatf("rnd%0d_data", i), bus.o_data, model_data());
            check($sformatf("rnd%0d_cnt", i), bus.o_bit_count, m_cnt);
            check($sformatf("rnd%0d_deb", i), bus.o_buttons_debounced, m_deb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
